stack_unit: RTL and testbench

- Hardware operand stack that services the push/pop/tos commands issued by the multi-cycle stack processor datapath.
- Sits beside the datapath register file. It accepts data to push, and returns the popped or top-of-stack value one cycle later through a registered output.
- Tracks fill level and flags overflow and underflow, so the controller and testbench can detect misuse.

---
 rtl/stack_pkg.sv | 12 +
 rtl/stack_ram.sv | 21 ++
 rtl/stack_unit.sv | 137 +++++++++++++
 tb/tb_stack_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants and command encoding for the hardware operand stack.
package stack_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    TOS  = 2'd3
  } op_e;
endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the controller gates reads with empty.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/stack_unit.sv
// Operand stack: push/pop/tos decode, fill level, registered read data and
// sticky overflow/underflow flags.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic [PW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf
);
  logic [PW:0]      cnt_m1;
  logic [PW-1:0]    top_idx;
  logic [WIDTH-1:0] rdata;
  logic             we;
  logic [PW-1:0]    waddr;
  logic [PW:0]      count_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             dv_nxt;
  logic             ovf_set;
  logic             udf_set;
  op_e              op;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign cnt_m1  = count - (PW+1)'(1);
  // When full, count-1 is DEPTH-1, so one read port covers every read case.
  assign top_idx = cnt_m1[PW-1:0];

  stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (top_idx),
    .rdata (rdata)
  );

  // Single-command view; push&pop together is handled ahead of this.
  always_comb begin
    if (pop)       op = POP;
    else if (push) op = PUSH;
    else if (tos)  op = TOS;
    else           op = NOP;
  end

  always_comb begin
    we        = 1'b0;
    waddr     = top_idx;
    count_nxt = count;
    dout_nxt  = dout;
    dv_nxt    = 1'b0;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    if (push && pop) begin
      if (!empty) begin
        dout_nxt = rdata;
        we       = 1'b1;
        dv_nxt   = 1'b1;
      end else begin
        // Empty stack cannot be full (DEPTH>=2), so the push always lands.
        we        = 1'b1;
        waddr     = count[PW-1:0];
        count_nxt = count + (PW+1)'(1);
        udf_set   = 1'b1;
      end
    end else begin
      case (op)
        POP: begin
          if (!empty) begin
            dout_nxt  = rdata;
            count_nxt = cnt_m1;
            dv_nxt    = 1'b1;
          end else begin
            udf_set = 1'b1;
          end
        end
        PUSH: begin
          if (!full) begin
            we        = 1'b1;
            waddr     = count[PW-1:0];
            count_nxt = count + (PW+1)'(1);
            if (tos) begin
              dout_nxt = din;
              dv_nxt   = 1'b1;
            end
          end else begin
            ovf_set = 1'b1;
            if (tos) begin
              dout_nxt = rdata;
              dv_nxt   = 1'b1;
            end
          end
        end
        TOS: begin
          if (!empty) begin
            dout_nxt = rdata;
            dv_nxt   = 1'b1;
          end else begin
            udf_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      count  <= count_nxt;
      dout   <= dout_nxt;
      dvalid <= dv_nxt;
      // A new error in the same cycle as err_clr keeps the flag set.
      ovf    <= ovf_set | (ovf & ~err_clr);
      udf    <= udf_set | (udf & ~err_clr);
    end
  end
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: default DEPTH=16 instance plus a DEPTH=4
// instance sharing the same command inputs.
module tb_stack_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] dout, dout4;
  logic       dvalid, dvalid4;
  logic [4:0] count;
  logic [2:0] count4;
  logic       full, empty, ovf, udf;
  logic       full4, empty4, ovf4, udf4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_unit u16 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
    .err_clr(err_clr), .dout(dout), .dvalid(dvalid), .count(count),
    .full(full), .empty(empty), .ovf(ovf), .udf(udf)
  );

  stack_unit #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
    .err_clr(err_clr), .dout(dout4), .dvalid(dvalid4), .count(count4),
    .full(full4), .empty(empty4), .ovf(ovf4), .udf(udf4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 0; pop = 0; tos = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (count !== 5'd0 || dout !== 8'h00 || dvalid !== 1'b0 || ovf !== 1'b0 ||
        udf !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d dout=%h dvalid=%b ovf=%b udf=%b empty=%b full=%b (want 0 00 0 0 0 1 0)",
               count, dout, dvalid, ovf, udf, empty, full);
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_push_tos();
    push = 1; din = 8'h11; cyc();
    din = 8'h22; cyc();
    checks++;
    if (dvalid !== 1'b0) begin
      errors++; $display("FAIL push_dvalid: dvalid=%b want 0", dvalid);
    end
    din = 8'h33; cyc();
    push = 0;
    checks++;
    if (count !== 5'd3 || empty !== 1'b0 || dvalid !== 1'b0) begin
      errors++;
      $display("FAIL push3: count=%0d empty=%b dvalid=%b want 3 0 0", count, empty, dvalid);
    end
    tos = 1; cyc(); tos = 0;
    checks++;
    if (dout !== 8'h33 || dvalid !== 1'b1 || count !== 5'd3) begin
      errors++;
      $display("FAIL tos: dout=%h dvalid=%b count=%0d want 33 1 3", dout, dvalid, count);
    end
  endtask

  task automatic test_pop_b2b();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h33; exp_d[1] = 8'h22; exp_d[2] = 8'h11;
    pop = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (dout !== exp_d[i] || dvalid !== 1'b1 || count !== 5'(2 - i)) begin
        errors++;
        $display("FAIL pop%0d: dout=%h dvalid=%b count=%0d want %h 1 %0d",
                 i, dout, dvalid, count, exp_d[i], 2 - i);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL pop_empty: empty=%b want 1", empty);
    end
    cyc(); pop = 0;
    checks++;
    if (udf !== 1'b1 || dvalid !== 1'b0 || dout !== 8'h11 || count !== 5'd0) begin
      errors++;
      $display("FAIL pop_underflow: udf=%b dvalid=%b dout=%h count=%0d want 1 0 11 0",
               udf, dvalid, dout, count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    push = 1;
    for (int i = 1; i <= 4; i++) begin
      din = 8'(i); cyc();
    end
    checks++;
    if (full4 !== 1'b1 || count4 !== 3'd4 || ovf4 !== 1'b0) begin
      errors++;
      $display("FAIL fill4: full=%b count=%0d ovf=%b want 1 4 0", full4, count4, ovf4);
    end
    din = 8'd5; cyc();
    checks++;
    if (ovf4 !== 1'b1 || count4 !== 3'd4 || dvalid4 !== 1'b0) begin
      errors++;
      $display("FAIL overflow: ovf=%b count=%0d dvalid=%b want 1 4 0", ovf4, count4, dvalid4);
    end
    checks++;
    if (ovf !== 1'b0 || count !== 5'd5) begin
      errors++;
      $display("FAIL no_ovf16: ovf=%b count=%0d want 0 5", ovf, count);
    end
    din = 8'd6; tos = 1; cyc(); tos = 0;
    checks++;
    if (dout4 !== 8'd4 || dvalid4 !== 1'b1 || count4 !== 3'd4) begin
      errors++;
      $display("FAIL push_tos_full: dout=%h dvalid=%b count=%0d want 04 1 4", dout4, dvalid4, count4);
    end
    push = 0; pop = 1; cyc(); pop = 0;
    checks++;
    if (dout4 !== 8'd4 || dvalid4 !== 1'b1 || count4 !== 3'd3 || full4 !== 1'b0) begin
      errors++;
      $display("FAIL pop_after_ovf: dout=%h dvalid=%b count=%0d full=%b want 04 1 3 0",
               dout4, dvalid4, count4, full4);
    end
  endtask

  task automatic test_replace();
    do_reset();
    push = 1; din = 8'hA0; cyc();
    din = 8'hB0; cyc();
    pop = 1; din = 8'hC0; cyc();
    push = 0; pop = 0;
    checks++;
    if (dout !== 8'hB0 || dvalid !== 1'b1 || count !== 5'd2 || udf !== 1'b0) begin
      errors++;
      $display("FAIL replace: dout=%h dvalid=%b count=%0d udf=%b want b0 1 2 0", dout, dvalid, count, udf);
    end
    tos = 1; cyc(); tos = 0;
    checks++;
    if (dout !== 8'hC0 || dvalid !== 1'b1) begin
      errors++; $display("FAIL replace_tos: dout=%h dvalid=%b want c0 1", dout, dvalid);
    end
    do_reset();
    push = 1; pop = 1; din = 8'h7E; cyc(); idle();
    checks++;
    if (count !== 5'd1 || udf !== 1'b1 || dvalid !== 1'b0) begin
      errors++;
      $display("FAIL replace_empty: count=%0d udf=%b dvalid=%b want 1 1 0", count, udf, dvalid);
    end
  endtask

  task automatic test_push_with_tos();
    do_reset();
    push = 1; tos = 1; din = 8'h5A; cyc(); idle();
    checks++;
    if (dout !== 8'h5A || dvalid !== 1'b1 || count !== 5'd1) begin
      errors++;
      $display("FAIL push_tos: dout=%h dvalid=%b count=%0d want 5a 1 1", dout, dvalid, count);
    end
    cyc();
    checks++;
    if (dvalid !== 1'b0 || dout !== 8'h5A) begin
      errors++; $display("FAIL idle_hold: dvalid=%b dout=%h want 0 5a", dvalid, dout);
    end
  endtask

  task automatic test_err_clr();
    do_reset();
    pop = 1; cyc();
    checks++;
    if (udf !== 1'b1) begin
      errors++; $display("FAIL udf_set: udf=%b want 1", udf);
    end
    err_clr = 1; cyc();
    checks++;
    if (udf !== 1'b1) begin
      errors++; $display("FAIL udf_set_wins: udf=%b want 1", udf);
    end
    pop = 0; cyc(); err_clr = 0;
    checks++;
    if (udf !== 1'b0) begin
      errors++; $display("FAIL udf_clr: udf=%b want 0", udf);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push = 1; din = 8'h01; cyc();
    din = 8'h02; cyc();
    din = 8'h03; cyc();
    push = 0; tos = 1; cyc(); tos = 0;
    checks++;
    if (dout !== 8'h03 || dvalid !== 1'b1 || count !== 5'd3) begin
      errors++;
      $display("FAIL pre_reset: dout=%h dvalid=%b count=%0d want 03 1 3", dout, dvalid, count);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || dvalid !== 1'b0 || dout !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: count=%0d dvalid=%b dout=%h empty=%b want 0 0 00 1",
               count, dvalid, dout, empty);
    end
    @(negedge clk) rst = 1'b1;
    tos = 1; cyc(); tos = 0;
    checks++;
    if (udf !== 1'b1 || dvalid !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL tos_after_reset: udf=%b dvalid=%b dout=%h want 1 0 00", udf, dvalid, dout);
    end
  endtask

  initial begin
    test_reset();
    test_push_tos();
    test_pop_b2b();
    test_overflow();
    test_replace();
    test_push_with_tos();
    test_err_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
